serial_magnitude_comparator: RTL

- Parametrised, bit-serial, MSB-first magnitude comparator with a start/busy/done handshake.
- Successor to the 4-bit combinational compare/select logic: operand width is a parameter, and it adds LT, MIN and NE modes.
- Optional early exit at the first differing bit.
- Sits between operand registers and any consumer that can tolerate multi-cycle latency in exchange for small area at large WIDTH.

---
 rtl/serial_magnitude_comparator.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator.
// Start/busy/done handshake, EQ/GT/LT/MAX/MIN/NE modes.
module serial_magnitude_comparator #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1,
  parameter int CW         = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             illegal,
  output logic [CW-1:0]    cycles
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] yr;
  logic [2:0]       selr;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic             found;
  logic             dgt;
  logic             dlt;

  logic             bx;
  logic             diff;
  logic             new_dec;
  logic             fin;
  logic             fgt;
  logic             flt;
  logic             feq;
  logic [CW-1:0]    cnt_n;
  logic [WIDTH-1:0] res_c;

  // Current bit decision and the final status/result if this is the last scan
  always_comb begin
    bx      = xr[idx];
    diff    = xr[idx] ^ yr[idx];
    new_dec = diff & ~found;
    fin     = (idx == '0) | (new_dec & EARLY_EXIT);
    fgt     = found ? dgt : (diff & bx);
    flt     = found ? dlt : (diff & ~bx);
    feq     = ~fgt & ~flt;
    cnt_n   = cnt + CW'(1);
    res_c   = '0;
    case (selr)
      3'b000:  res_c = {{(WIDTH-1){1'b0}}, feq};
      3'b001:  res_c = {{(WIDTH-1){1'b0}}, fgt};
      3'b010:  res_c = {{(WIDTH-1){1'b0}}, flt};
      3'b011:  res_c = fgt ? xr : yr;
      3'b100:  res_c = flt ? xr : yr;
      3'b101:  res_c = {{(WIDTH-1){1'b0}}, ~feq};
      default: res_c = '0;
    endcase
  end

  // Control FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      xr      <= '0;
      yr      <= '0;
      selr    <= '0;
      idx     <= '0;
      cnt     <= '0;
      found   <= 1'b0;
      dgt     <= 1'b0;
      dlt     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      eq      <= 1'b0;
      gt      <= 1'b0;
      lt      <= 1'b0;
      illegal <= 1'b0;
      cycles  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            xr    <= x;
            yr    <= y;
            selr  <= sel;
            idx   <= IW'(WIDTH - 1);
            cnt   <= '0;
            found <= 1'b0;
            dgt   <= 1'b0;
            dlt   <= 1'b0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          cnt <= cnt_n;
          if (new_dec) begin
            found <= 1'b1;
            dgt   <= bx;
            dlt   <= ~bx;
          end
          if (fin) begin
            state   <= DONE;
            done    <= 1'b1;
            result  <= res_c;
            eq      <= feq;
            gt      <= fgt;
            lt      <= flt;
            illegal <= selr[2] & selr[1];
            cycles  <= cnt_n;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
